// File: rtl/regfile_dump_engine_pkg.sv
// Shared definitions for the register-file dump engine: FSM encoding and address sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package regfile_dump_engine_pkg;

    // Dump engine control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Ceiling log2, same rounding as the register file uses for its address port
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_dump_engine.sv
// Walks every register through one read port and streams {addr, data} beats out.
// Latency: first beat valid 1+READ_LATENCY cycles after start; one beat per 2+READ_LATENCY cycles.
// Backpressure: beat held stable in OUT until out_ready; no new read issues until it is taken.
module regfile_dump_engine
    import regfile_dump_engine_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_REGISTERS = 4,
    parameter int READ_LATENCY  = 1,
    parameter int ADDR_WIDTH    = clog2(NUM_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGISTERS - 1);
    localparam bit                    HAS_WAIT  = (READ_LATENCY == 1);

    state_e                  state_q,     state_d;
    // The address counter doubles as the read address: it only moves on entry to
    // ISSUE, so it naturally holds its value everywhere else.
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic                    out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q,  out_addr_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic                    out_last_q,  out_last_d;
    logic                    done_q,      done_d;

    // Next-state, counter and output-holding-register logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    addr_d  = '0;
                end
            end
            ST_ISSUE: begin
                if (HAS_WAIT) begin
                    state_d = ST_WAIT;
                end else begin
                    // Combinational read: data for addr_q is present right now
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                    out_addr_d  = addr_q;
                    out_data_d  = rd_data;
                    out_last_d  = (addr_q == LAST_ADDR);
                end
            end
            ST_WAIT: begin
                state_d     = ST_OUT;
                out_valid_d = 1'b1;
                out_addr_d  = addr_q;
                out_data_d  = rd_data;
                out_last_d  = (addr_q == LAST_ADDR);
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any beat in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign rd_addr   = addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/regfile_dump_engine.md
# regfile_dump_engine

Sequential read-out engine for the core register file: on a start pulse it walks every register through one read port, from address 0 to NUM_REGISTERS-1, and streams each {address, data} pair out on a valid/ready interface. It is the reader counterpart to the file-driven write stimulus. It connects to a W0RM_Core_RegisterFile read port and feeds a checker, a debug UART or a scan-out path.

## Interface
- DATA_WIDTH, 8: register width.
- NUM_REGISTERS, 4: registers to dump; any value ≥ 2, not necessarily a power of two.
- ADDR_WIDTH, clog2(NUM_REGISTERS): address width. Derived; not overridden.
- READ_LATENCY, 1: register-file read latency in cycles; legal values are 0 and 1.

- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.
- rd_addr  out  ADDR_WIDTH  register-file read address.
- rd_data  in  DATA_WIDTH  register-file read data.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- out_addr  out  ADDR_WIDTH  address of the current beat.
- out_data  out  DATA_WIDTH  data of the current beat.
- out_last  out  1  beat is for address NUM_REGISTERS-1.

## Operation
- Reset values: state IDLE. busy, done, out_valid and out_last are 0. rd_addr, out_addr and out_data are 0.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE → ISSUE on start. The address counter loads 0.
- ISSUE drives rd_addr = counter. It goes to WAIT if READ_LATENCY = 1, otherwise to OUT.
- WAIT holds rd_addr, then goes to OUT.
- On entering OUT, the engine captures rd_data into out_data and the counter into out_addr. out_valid is set, and out_last = (counter == NUM_REGISTERS-1).
- OUT holds out_valid, out_addr, out_data and out_last stable until out_ready is high at a rising edge (the handshake).
- On handshake with out_last = 0, the counter increments and the FSM goes to ISSUE.
- On handshake with out_last = 1, the FSM goes to IDLE and done pulses for one cycle.
- out_valid clears on handshake. out_ready is ignored while out_valid is 0.
- start is ignored while busy.
- start in the cycle done is high is accepted, because the FSM is already in IDLE.
- The counter never exceeds NUM_REGISTERS-1, so there is no wrap. The next dump restarts at 0.
- reset_n low at any point, including mid-beat, forces all reset values immediately. Any pending beat is dropped, not completed.
- Outside ISSUE/WAIT, rd_addr holds its last value.

## Timing
- Let start be sampled at edge E0. The first out_valid is high after edge E0 + 1 + READ_LATENCY.
- After a handshake at edge H, the next out_valid is high after edge H + 1 + READ_LATENCY.
- Peak throughput with out_ready tied high is one beat per 2 + READ_LATENCY cycles.
- Full dump with out_ready tied high: done is high in the cycle after edge E0 + NUM_REGISTERS·(2+READ_LATENCY), and busy falls in the same cycle.
- rd_data is sampled only at the edge leaving ISSUE (latency 0) or WAIT (latency 1). Its value at any other time has no effect.
- All outputs are registered. There is no combinational path from out_ready or rd_data to any output.

## Structure
- Shared core package holds:
  - the FSM state encoding constants (IDLE, ISSUE, WAIT, OUT);
  - the clog2 function used for ADDR_WIDTH, so it matches W0RM_Core_RegisterFile.
- Single module, no sub-modules. The output holding register is small enough to stay inline.

## Test plan
- Latency-1 dump with a register-file model holding 0x11, 0x22, 0x33, 0x44 and out_ready tied high → beats (0,0x11), (1,0x22), (2,0x33), (3,0x44) with out_last only on address 3. out_valid first high 2 edges after start; done at E0+12.
- Backpressure: out_ready low for 5 cycles on beat 1 → out_addr=1 and out_data=0x22 stay stable with out_valid high. The beat is delivered exactly once, and no address is skipped or repeated.
- start pulsed again mid-dump, plus start in the done cycle → the mid-dump pulse has no effect; the done-cycle pulse starts a second full dump from address 0.
- reset_n low during beat 2 → busy, out_valid and done drop to 0 immediately. No further beats appear. A fresh start then dumps from address 0.
- READ_LATENCY=0, NUM_REGISTERS=5, ADDR_WIDTH=3 → 5 beats at 2-cycle spacing with out_last on address 4. rd_addr never exceeds 4.
- out_ready pulsed while idle → no beats and no state change.
